cache_control_nway: RTL

Parametrised N-way set-associative cache controller FSM. It generalises the 2-way controller to WAYS ways and adds a real write-hit path, a write-allocate/no-allocate mode, a memory request timeout and multi-hit detection. It sits between the CPU memory port and the external main-memory interface, and drives the tag, data, valid/dirty and replacement arrays of the cache datapath. It does not store tags or data.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_control_nway_if.sv | 47 ++++
 rtl/cache_onehot_enc.sv | 24 ++
 rtl/cache_control_nway.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way cache controller and its replacement unit.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WB    = 3'd2,
    FILL  = 3'd3,
    WT    = 3'd4,
    ERROR = 3'd5
  } cache_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } cache_op_t;

  function automatic int unsigned way_w(input int unsigned ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_control_nway_if.sv
// CPU port, main-memory port and cache datapath controls seen by the N-way controller.
interface cache_control_nway_if #(
  parameter int unsigned WAYS = 4
);
  localparam int unsigned WW = cache_pkg::way_w(WAYS);

  logic            cpu_read;
  logic            cpu_write;
  logic [WAYS-1:0] hit_way;
  logic [WAYS-1:0] is_valid;
  logic [WAYS-1:0] is_dirty;
  logic [WW-1:0]   victim_way;
  logic            mem_ack;

  logic            cpu_mem_valid;
  logic            lru_load;
  logic [WW-1:0]   lru_way;
  logic [WAYS-1:0] load_tag;
  logic [WAYS-1:0] load_line;
  logic [WAYS-1:0] load_bytes;
  logic            data_in_select;
  logic [WAYS-1:0] set_dirty;
  logic [WAYS-1:0] write_dirty;
  logic [WAYS-1:0] set_valid;
  logic [WAYS-1:0] write_valid;
  logic            mem_read;
  logic            mem_write;
  logic [WW-1:0]   mem_wb_way;
  logic            mem_wr_cpu;
  logic            busy;
  logic            error;

  modport master (
    output cpu_read, cpu_write, hit_way, is_valid, is_dirty, victim_way, mem_ack,
    input  cpu_mem_valid, lru_load, lru_way, load_tag, load_line, load_bytes,
           data_in_select, set_dirty, write_dirty, set_valid, write_valid,
           mem_read, mem_write, mem_wb_way, mem_wr_cpu, busy, error
  );

  modport slave (
    input  cpu_read, cpu_write, hit_way, is_valid, is_dirty, victim_way, mem_ack,
    output cpu_mem_valid, lru_load, lru_way, load_tag, load_line, load_bytes,
           data_in_select, set_dirty, write_dirty, set_valid, write_valid,
           mem_read, mem_write, mem_wb_way, mem_wr_cpu, busy, error
  );

endinterface

// File: rtl/cache_onehot_enc.sv
// One-hot to index encoder with any/multi flags; idx is only meaningful when multi is low.
module cache_onehot_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any,
  output logic                 multi
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) idx = idx | IW'(i);
    end
  end

  assign any   = |vec;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: hit/miss sequencing, writeback, fill,
// write-through for non-allocating writes, memory timeout and multi-hit trapping.
module cache_control_nway
  import cache_pkg::*;
#(
  parameter int unsigned WAYS           = 4,
  parameter int unsigned WRITE_ALLOCATE = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_control_nway_if.slave bus
);

  localparam int unsigned WW = way_w(WAYS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  cache_state_t    r_state;
  cache_state_t    w_state_next;
  cache_op_t       r_op;
  logic [WW-1:0]   r_vict;
  logic [TW-1:0]   r_tmo;
  logic            r_retried;

  logic [WAYS-1:0] w_hit_vec;
  logic [WW-1:0]   w_hit_idx;
  logic            w_hit_any;
  logic            w_hit_multi;
  logic            w_hit_ok;
  logic [WAYS-1:0] w_vict_oh;
  logic            w_vict_dirty;
  logic            w_mem_wait;
  logic            w_tmo_expired;
  logic            w_no_alloc;

  assign w_hit_vec = bus.hit_way & bus.is_valid;

  cache_onehot_enc #(.N(WAYS)) u_hit_enc (
    .vec   (w_hit_vec),
    .idx   (w_hit_idx),
    .any   (w_hit_any),
    .multi (w_hit_multi)
  );

  assign w_hit_ok      = w_hit_any & ~w_hit_multi;
  assign w_vict_dirty  = bus.is_valid[bus.victim_way] & bus.is_dirty[bus.victim_way];
  assign w_vict_oh     = WAYS'(1) << r_vict;
  assign w_mem_wait    = (r_state == WB) || (r_state == FILL) || (r_state == WT);
  assign w_tmo_expired = w_mem_wait && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_no_alloc    = (r_op == WRITE) && (WRITE_ALLOCATE == 0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Transaction context: op, victim, retry flag and memory wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= READ;
      r_vict    <= '0;
      r_retried <= 1'b0;
      r_tmo     <= '0;
    end else begin
      if (r_state == IDLE && (bus.cpu_write || bus.cpu_read))
        r_op <= bus.cpu_write ? WRITE : READ;
      if (r_state == CHECK && (w_state_next == WB || w_state_next == FILL))
        r_vict <= bus.victim_way;
      if (r_state == IDLE)
        r_retried <= 1'b0;
      else if (r_state == FILL && bus.mem_ack)
        r_retried <= 1'b1;
      if (w_state_next != r_state) r_tmo <= '0;
      else if (w_mem_wait)         r_tmo <= r_tmo + TW'(1);
    end
  end

  // Next-state logic; a mem_ack always beats a coincident timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.cpu_write || bus.cpu_read) w_state_next = CHECK;
      end
      CHECK: begin
        if (w_hit_multi)       w_state_next = ERROR;
        else if (w_hit_any)    w_state_next = IDLE;
        else if (r_retried)    w_state_next = ERROR;
        else if (w_no_alloc)   w_state_next = WT;
        else if (w_vict_dirty) w_state_next = WB;
        else                   w_state_next = FILL;
      end
      WB: begin
        if (bus.mem_ack)         w_state_next = FILL;
        else if (w_tmo_expired)  w_state_next = ERROR;
      end
      FILL: begin
        if (bus.mem_ack)         w_state_next = CHECK;
        else if (w_tmo_expired)  w_state_next = ERROR;
      end
      WT: begin
        if (bus.mem_ack)         w_state_next = IDLE;
        else if (w_tmo_expired)  w_state_next = ERROR;
      end
      ERROR:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from state and current inputs
  always_comb begin
    bus.cpu_mem_valid  = 1'b0;
    bus.lru_load       = 1'b0;
    bus.lru_way        = '0;
    bus.load_tag       = '0;
    bus.load_line      = '0;
    bus.load_bytes     = '0;
    bus.data_in_select = 1'b0;
    bus.set_dirty      = '0;
    bus.write_dirty    = '0;
    bus.set_valid      = '0;
    bus.write_valid    = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_wb_way     = '0;
    bus.mem_wr_cpu     = 1'b0;
    bus.busy           = (r_state != IDLE);
    bus.error          = 1'b0;
    case (r_state)
      CHECK: begin
        if (w_hit_ok) begin
          bus.cpu_mem_valid = 1'b1;
          bus.lru_load      = 1'b1;
          bus.lru_way       = w_hit_idx;
          if (r_op == WRITE) begin
            bus.load_bytes  = w_hit_vec;
            bus.set_dirty   = w_hit_vec;
            bus.write_dirty = w_hit_vec;
          end
        end
      end
      WB: begin
        bus.mem_write  = 1'b1;
        bus.mem_wb_way = r_vict;
      end
      FILL: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ack) begin
          bus.load_line      = w_vict_oh;
          bus.load_tag       = w_vict_oh;
          bus.set_valid      = w_vict_oh;
          bus.write_valid    = w_vict_oh;
          bus.write_dirty    = w_vict_oh;
          bus.data_in_select = 1'b1;
        end
      end
      WT: begin
        bus.mem_write  = 1'b1;
        bus.mem_wr_cpu = 1'b1;
        if (bus.mem_ack) bus.cpu_mem_valid = 1'b1;
      end
      ERROR: begin
        bus.error         = 1'b1;
        bus.cpu_mem_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
